// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark block address generator.
package wm_pkg;

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_SETUP   = 7'b0000010,
    S_FETCH_P = 7'b0000100,
    S_FETCH_W = 7'b0001000,
    S_WAIT    = 7'b0010000,
    S_NEXT    = 7'b0100000,
    S_FIN     = 7'b1000000
  } state_t;

  localparam logic MODE_SEQ  = 1'b0;
  localparam logic MODE_INTL = 1'b1;

  localparam logic SRC_PRIM = 1'b0;
  localparam logic SRC_WMK  = 1'b1;

endpackage

// File: rtl/wm_block_addr_gen_if.sv
// Address stream from the block walker to the data-bank reader.
interface wm_block_addr_gen_if #(
  parameter int ADDR_W = 21,
  parameter int CNT_W  = 14
);

  logic [ADDR_W-1:0] addr;
  logic              addr_src;
  logic [1:0]        addr_ch;
  logic              addr_valid;
  logic              addr_ready;
  logic              blk_last;
  logic [CNT_W-1:0]  blk_idx;

  modport master (
    output addr, addr_src, addr_ch, addr_valid, blk_last, blk_idx,
    input  addr_ready
  );

  modport slave (
    input  addr, addr_src, addr_ch, addr_valid, blk_last, blk_idx,
    output addr_ready
  );

endinterface

// File: rtl/wm_block_cursor.sv
// Walks row/column/channel inside one (possibly edge-clipped) block and
// produces the word offset of the current beat with incremental pointers.
module wm_block_cursor #(
  parameter int ADDR_W = 21,
  parameter int DIM_W  = 10,
  parameter int BLK_W  = 7,
  parameter int N_CH   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_ptr,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [DIM_W-1:0]  x0,
  input  logic [DIM_W-1:0]  y0,
  input  logic [BLK_W-1:0]  blk_w,
  input  logic [BLK_W-1:0]  blk_h,
  output logic [ADDR_W-1:0] offset,
  output logic [1:0]        ch,
  output logic              last,
  output logic              edge_x,
  output logic              edge_y
);

  localparam logic [ADDR_W-1:0] CH_STEP = ADDR_W'(N_CH);
  localparam logic [1:0]        CH_LAST = 2'(N_CH - 1);

  logic [DIM_W-1:0]  rem_w, rem_h;
  logic [BLK_W-1:0]  ext_w_m1, ext_h_m1;
  logic [BLK_W-1:0]  r, c;
  logic [ADDR_W-1:0] row_ptr, pix_ptr;
  logic              ch_end, c_end, r_end;

  // A block touching the right/bottom edge is clipped to what remains.
  always_comb begin
    rem_w    = img_w - x0;
    rem_h    = img_h - y0;
    edge_x   = rem_w <= DIM_W'(blk_w);
    edge_y   = rem_h <= DIM_W'(blk_h);
    ext_w_m1 = (edge_x ? rem_w[BLK_W-1:0] : blk_w) - BLK_W'(1);
    ext_h_m1 = (edge_y ? rem_h[BLK_W-1:0] : blk_h) - BLK_W'(1);
    ch_end   = ch == CH_LAST;
    c_end    = c == ext_w_m1;
    r_end    = r == ext_h_m1;
    last     = ch_end && c_end && r_end;
    offset   = pix_ptr + ADDR_W'(ch);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r       <= '0;
      c       <= '0;
      ch      <= '0;
      row_ptr <= '0;
      pix_ptr <= '0;
    end else if (load) begin
      r       <= '0;
      c       <= '0;
      ch      <= '0;
      row_ptr <= load_ptr;
      pix_ptr <= load_ptr;
    end else if (advance) begin
      if (!ch_end) begin
        ch <= ch + 2'd1;
      end else begin
        ch <= '0;
        if (!c_end) begin
          c       <= c + BLK_W'(1);
          pix_ptr <= pix_ptr + CH_STEP;
        end else begin
          c       <= '0;
          r       <= r + BLK_W'(1);
          row_ptr <= row_ptr + row_stride;
          pix_ptr <= row_ptr + row_stride;
        end
      end
    end
  end

endmodule

// File: rtl/wm_block_addr_gen.sv
// Block-by-block read address generator for the watermarking datapath:
// owns the run FSM, block origin and primary/watermark sequencing.
module wm_block_addr_gen
  import wm_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DIM_W  = 10,
  parameter int BLK_W  = 7,
  parameter int N_CH   = 1,
  parameter int CNT_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DIM_W-1:0]    cfg_img_w,
  input  logic [DIM_W-1:0]    cfg_img_h,
  input  logic [BLK_W-1:0]    cfg_blk_w,
  input  logic [BLK_W-1:0]    cfg_blk_h,
  input  logic [ADDR_W-1:0]   cfg_p_base,
  input  logic [ADDR_W-1:0]   cfg_w_base,
  input  logic                cfg_mode,
  wm_block_addr_gen_if.master abus,
  input  logic                blk_done_in,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam logic [ADDR_W-1:0] CH_STEP = ADDR_W'(N_CH);

  state_t            state;
  logic              mode_q, src_q, valid_q;
  logic [DIM_W-1:0]  img_w_q, img_h_q, x0, y0;
  logic [BLK_W-1:0]  blk_w_q, blk_h_q;
  logic [ADDR_W-1:0] p_base_q, w_base_q;
  logic [ADDR_W-1:0] stride_q, col_step_q, brow_step_q;
  logic [ADDR_W-1:0] org_ptr, row_org_ptr;
  logic [CNT_W-1:0]  idx;

  logic              fire, cur_load, cur_adv, cfg_bad;
  logic [ADDR_W-1:0] load_ptr, cur_off;
  logic [1:0]        cur_ch;
  logic              cur_last, edge_x, edge_y;

  // Cursor restarts at the block origin on entry and before the watermark pass.
  always_comb begin
    fire     = valid_q && abus.addr_ready;
    cur_load = (state == S_SETUP) || (state == S_NEXT) ||
               ((state == S_FETCH_P) && (mode_q == MODE_SEQ) && fire && cur_last);
    cur_adv  = fire && !cur_last && ((mode_q == MODE_SEQ) || (src_q == SRC_WMK));
    load_ptr = (state == S_SETUP) ? '0 : org_ptr;
    cfg_bad  = (cfg_blk_w == '0) || (cfg_blk_h == '0) ||
               (cfg_img_w == '0) || (cfg_img_h == '0) ||
               (DIM_W'(cfg_blk_w) > cfg_img_w) || (DIM_W'(cfg_blk_h) > cfg_img_h);
  end

  wm_block_cursor #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W),
    .BLK_W  (BLK_W),
    .N_CH   (N_CH)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .load       (cur_load),
    .advance    (cur_adv),
    .load_ptr   (load_ptr),
    .row_stride (stride_q),
    .img_w      (img_w_q),
    .img_h      (img_h_q),
    .x0         (x0),
    .y0         (y0),
    .blk_w      (blk_w_q),
    .blk_h      (blk_h_q),
    .offset     (cur_off),
    .ch         (cur_ch),
    .last       (cur_last),
    .edge_x     (edge_x),
    .edge_y     (edge_y)
  );

  assign abus.addr       = ((src_q == SRC_WMK) ? w_base_q : p_base_q) + cur_off;
  assign abus.addr_src   = src_q;
  assign abus.addr_ch    = cur_ch;
  assign abus.addr_valid = valid_q;
  assign abus.blk_last   = valid_q && (src_q == SRC_WMK) && cur_last;
  assign abus.blk_idx    = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      mode_q      <= MODE_SEQ;
      src_q       <= SRC_PRIM;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      img_w_q     <= '0;
      img_h_q     <= '0;
      blk_w_q     <= '0;
      blk_h_q     <= '0;
      p_base_q    <= '0;
      w_base_q    <= '0;
      stride_q    <= '0;
      col_step_q  <= '0;
      brow_step_q <= '0;
      x0          <= '0;
      y0          <= '0;
      org_ptr     <= '0;
      row_org_ptr <= '0;
      idx         <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err  <= 1'b0;
              mode_q   <= cfg_mode;
              img_w_q  <= cfg_img_w;
              img_h_q  <= cfg_img_h;
              blk_w_q  <= cfg_blk_w;
              blk_h_q  <= cfg_blk_h;
              p_base_q <= cfg_p_base;
              w_base_q <= cfg_w_base;
              busy     <= 1'b1;
              state    <= S_SETUP;
            end
          end
        end
        // Per-run strides are multiplied once here; beats only add.
        S_SETUP: begin
          stride_q    <= ADDR_W'(img_w_q) * CH_STEP;
          col_step_q  <= ADDR_W'(blk_w_q) * CH_STEP;
          brow_step_q <= ADDR_W'(blk_h_q) * ADDR_W'(img_w_q) * CH_STEP;
          x0          <= '0;
          y0          <= '0;
          org_ptr     <= '0;
          row_org_ptr <= '0;
          idx         <= '0;
          src_q       <= SRC_PRIM;
          valid_q     <= 1'b1;
          state       <= S_FETCH_P;
        end
        S_FETCH_P: begin
          if (fire) begin
            if (mode_q == MODE_SEQ) begin
              if (cur_last) begin
                src_q <= SRC_WMK;
                state <= S_FETCH_W;
              end
            end else if (src_q == SRC_PRIM) begin
              src_q <= SRC_WMK;
            end else begin
              src_q <= SRC_PRIM;
              if (cur_last) begin
                valid_q <= 1'b0;
                state   <= S_WAIT;
              end
            end
          end
        end
        S_FETCH_W: begin
          if (fire && cur_last) begin
            valid_q <= 1'b0;
            state   <= S_WAIT;
          end
        end
        // Raster step: right along the block row, then wrap to the next row.
        S_WAIT: begin
          if (blk_done_in) begin
            if (edge_x && edge_y) begin
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              idx <= idx + CNT_W'(1);
              if (edge_x) begin
                x0          <= '0;
                y0          <= y0 + DIM_W'(blk_h_q);
                row_org_ptr <= row_org_ptr + brow_step_q;
                org_ptr     <= row_org_ptr + brow_step_q;
              end else begin
                x0      <= x0 + DIM_W'(blk_w_q);
                org_ptr <= org_ptr + col_step_q;
              end
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          src_q   <= SRC_PRIM;
          valid_q <= 1'b1;
          state   <= S_FETCH_P;
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wm_block_addr_gen.sv
// Scoreboard bench for wm_block_addr_gen: one single-channel and one
// three-channel instance, expected beats built by a direct-formula model.
module tb_wm_block_addr_gen;

  localparam int AW = 21;
  localparam int DW = 10;
  localparam int BW = 7;
  localparam int CW = 14;

  typedef struct {
    logic [AW-1:0] addr;
    logic          src;
    logic [1:0]    ch;
    logic          last;
    logic [CW-1:0] idx;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          start1, start3, abort, blk_done, rdy, cfg_mode, sel;
  logic [DW-1:0] cfg_img_w, cfg_img_h;
  logic [BW-1:0] cfg_blk_w, cfg_blk_h;
  logic [AW-1:0] cfg_p_base, cfg_w_base;
  logic          busy1, done1, err1, busy3, done3, err3;

  logic [AW-1:0] o_addr;
  logic          o_src, o_valid, o_last, o_busy, o_done;
  logic [1:0]    o_ch;
  logic [CW-1:0] o_idx;

  beat_t         exp_q[$];
  logic [AW-1:0] cap[$];
  int            n_tests;
  int            n_fail;

  wm_block_addr_gen_if #(.ADDR_W(AW), .CNT_W(CW)) if1 ();
  wm_block_addr_gen_if #(.ADDR_W(AW), .CNT_W(CW)) if3 ();

  assign if1.addr_ready = rdy;
  assign if3.addr_ready = rdy;

  wm_block_addr_gen #(.ADDR_W(AW), .DIM_W(DW), .BLK_W(BW), .N_CH(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .cfg_blk_w(cfg_blk_w), .cfg_blk_h(cfg_blk_h),
    .cfg_p_base(cfg_p_base), .cfg_w_base(cfg_w_base), .cfg_mode(cfg_mode),
    .abus(if1), .blk_done_in(blk_done),
    .busy(busy1), .done(done1), .cfg_err(err1)
  );

  wm_block_addr_gen #(.ADDR_W(AW), .DIM_W(DW), .BLK_W(BW), .N_CH(3), .CNT_W(CW)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h),
    .cfg_blk_w(cfg_blk_w), .cfg_blk_h(cfg_blk_h),
    .cfg_p_base(cfg_p_base), .cfg_w_base(cfg_w_base), .cfg_mode(cfg_mode),
    .abus(if3), .blk_done_in(blk_done),
    .busy(busy3), .done(done3), .cfg_err(err3)
  );

  always #5 clk = ~clk;

  always_comb begin
    o_addr  = sel ? if3.addr       : if1.addr;
    o_src   = sel ? if3.addr_src   : if1.addr_src;
    o_ch    = sel ? if3.addr_ch    : if1.addr_ch;
    o_valid = sel ? if3.addr_valid : if1.addr_valid;
    o_last  = sel ? if3.blk_last   : if1.blk_last;
    o_idx   = sel ? if3.blk_idx    : if1.blk_idx;
    o_busy  = sel ? busy3          : busy1;
    o_done  = sel ? done3          : done1;
  end

  // Expected beats straight from base + ((y0+r)*img_w + x0+c)*N_CH + ch.
  task automatic build_expected(input int iw, input int ih, input int bw, input int bh,
                                input int pb, input int wb, input bit md, input int nch);
    int    ew, eh, s, idx;
    beat_t b;
    exp_q.delete();
    idx = 0;
    for (int y0 = 0; y0 < ih; y0 += bh) begin
      for (int x0 = 0; x0 < iw; x0 += bw) begin
        ew = (iw - x0 < bw) ? iw - x0 : bw;
        eh = (ih - y0 < bh) ? ih - y0 : bh;
        for (int p = 0; p < (md ? 1 : 2); p++)
          for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
              for (int ch = 0; ch < nch; ch++)
                for (int q = 0; q < (md ? 2 : 1); q++) begin
                  s      = md ? q : p;
                  b.addr = AW'((s == 1 ? wb : pb) + ((y0 + r) * iw + x0 + c) * nch + ch);
                  b.src  = (s == 1);
                  b.ch   = 2'(ch);
                  b.last = (s == 1) && (r == eh - 1) && (c == ew - 1) && (ch == nch - 1);
                  b.idx  = CW'(idx);
                  exp_q.push_back(b);
                end
        idx++;
      end
    end
  endtask

  task automatic set_cfg(input int iw, input int ih, input int bw, input int bh,
                         input int pb, input int wb, input bit md);
    cfg_img_w  = DW'(iw);
    cfg_img_h  = DW'(ih);
    cfg_blk_w  = BW'(bw);
    cfg_blk_h  = BW'(bh);
    cfg_p_base = AW'(pb);
    cfg_w_base = AW'(wb);
    cfg_mode   = md;
  endtask

  task automatic applyStimulus(input bit use3);
    @(posedge clk); #1;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  // Full run: compare every offered beat (stalls included) to the queue head,
  // release each block a few cycles after its last beat, then expect one done.
  task automatic run_walk(input bit use3, input int iw, input int ih, input int bw, input int bh,
                          input int pb, input int wb, input bit md, input bit rnd);
    int    nb, released, dones, cyc, wcnt;
    bit    waiting;
    beat_t e;
    build_expected(iw, ih, bw, bh, pb, wb, md, use3 ? 3 : 1);
    nb = ((iw + bw - 1) / bw) * ((ih + bh - 1) / bh);
    sel = use3;
    cap.delete();
    set_cfg(iw, ih, bw, bh, pb, wb, md);
    applyStimulus(use3);
    released = 0; dones = 0; cyc = 0; wcnt = 0; waiting = 1'b0;
    while ((released < nb || exp_q.size() != 0) && cyc < 3000) begin
      rdy      = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      blk_done = 1'b0;
      if (waiting) begin
        wcnt++;
        if (wcnt == 3) begin
          blk_done = 1'b1;
          waiting  = 1'b0;
          released++;
        end
      end
      @(negedge clk);
      if (o_done === 1'b1) dones++;
      if (waiting) begin
        n_tests++;
        if (o_valid !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL valid_in_wait: addr_valid=%b, expected 0", o_valid);
        end
      end else if (o_valid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL extra_beat: addr=%h, expected no beat", o_addr);
        end else begin
          e = exp_q[0];
          if (o_addr !== e.addr || o_src !== e.src || o_ch !== e.ch ||
              o_last !== e.last || o_idx !== e.idx) begin
            n_fail++;
            $display("[TB] FAIL beat: got addr=%h src=%b ch=%0d last=%b idx=%0d, expected addr=%h src=%b ch=%0d last=%b idx=%0d",
                     o_addr, o_src, o_ch, o_last, o_idx, e.addr, e.src, e.ch, e.last, e.idx);
          end
          if (rdy) begin
            cap.push_back(o_addr);
            void'(exp_q.pop_front());
            if (e.last) begin
              waiting = 1'b1;
              wcnt    = 0;
            end
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    blk_done = 1'b0;
    rdy      = 1'b1;
    n_tests++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("[TB] FAIL run_timeout: %0d beats left, %0d of %0d blocks released", exp_q.size(), released, nb);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (dones != 1) begin
      n_fail++;
      $display("[TB] FAIL done_count: got %0d pulses, expected 1", dones);
    end
    @(negedge clk);
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_after_run: got %b, expected 0", o_busy);
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy1", int'(busy1), 0);
    checkOutput("rst_done1", int'(done1), 0);
    checkOutput("rst_err1", int'(err1), 0);
    checkOutput("rst_valid1", int'(if1.addr_valid), 0);
    checkOutput("rst_addr1", int'(if1.addr), 0);
    checkOutput("rst_last1", int'(if1.blk_last), 0);
    checkOutput("rst_idx1", int'(if1.blk_idx), 0);
    checkOutput("rst_busy3", int'(busy3), 0);
    checkOutput("rst_valid3", int'(if3.addr_valid), 0);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_seq_square();
    logic [AW-1:0] ref8 [8];
    ref8 = '{21'h0A, 21'h0B, 21'h0E, 21'h0F, 21'h1A, 21'h1B, 21'h1E, 21'h1F};
    run_walk(1'b0, 4, 4, 2, 2, 'h0A, 'h1A, 1'b0, 1'b0);
    checkOutput("seq_beats", cap.size(), 32);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      checkOutput("seq_blk0_addr", int'(cap[i]), int'(ref8[i]));
  endtask

  task automatic test_interleave();
    logic [AW-1:0] ref8 [8];
    ref8 = '{21'h0A, 21'h1A, 21'h0B, 21'h1B, 21'h0E, 21'h1E, 21'h0F, 21'h1F};
    run_walk(1'b0, 4, 4, 2, 2, 'h0A, 'h1A, 1'b1, 1'b0);
    checkOutput("intl_beats", cap.size(), 32);
    for (int i = 0; i < 8 && i < cap.size(); i++)
      checkOutput("intl_blk0_addr", int'(cap[i]), int'(ref8[i]));
  endtask

  task automatic test_clip();
    run_walk(1'b0, 5, 3, 2, 2, 'h100, 'h200, 1'b0, 1'b0);
    checkOutput("clip_beats", cap.size(), 30);
  endtask

  task automatic test_multichannel();
    run_walk(1'b1, 2, 2, 2, 2, 0, 'h40, 1'b0, 1'b0);
    checkOutput("mch_beats", cap.size(), 24);
    for (int i = 0; i < 12 && i < cap.size(); i++)
      checkOutput("mch_prim_addr", int'(cap[i]), i);
    sel = 1'b0;
  endtask

  task automatic test_random_ready();
    run_walk(1'b0, 4, 4, 2, 2, 'h0A, 'h1A, 1'b0, 1'b1);
    checkOutput("rnd_beats", cap.size(), 32);
  endtask

  task automatic test_error_control();
    int seen, dones;
    sel = 1'b0;
    rdy = 1'b1;
    set_cfg(4, 4, 0, 2, 'h0A, 'h1A, 1'b0);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("err_set", int'(err1), 1);
    checkOutput("err_busy", int'(busy1), 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("err_kept_on_abort", int'(err1), 1);

    set_cfg(4, 4, 2, 2, 'h0A, 'h1A, 1'b0);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("err_cleared", int'(err1), 0);
    checkOutput("run_busy", int'(busy1), 1);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (if1.addr_valid === 1'b1) seen = 1;
    end
    checkOutput("fetch_reached", seen, 1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy1), 0);
    checkOutput("abort_valid", int'(if1.addr_valid), 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done1 === 1'b1) dones++;
    end
    checkOutput("abort_no_done", dones, 0);

    set_cfg(4, 4, 5, 2, 'h0A, 'h1A, 1'b0);
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("err_blk_too_wide", int'(err1), 1);
    run_walk(1'b0, 4, 4, 2, 2, 'h0A, 'h1A, 1'b1, 1'b0);
    checkOutput("err_after_good_run", int'(err1), 0);
  endtask

  task automatic test_reset_midrun();
    int seen;
    sel = 1'b0;
    rdy = 1'b0;
    set_cfg(4, 4, 2, 2, 'h0A, 'h1A, 1'b0);
    applyStimulus(1'b0);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (if1.addr_valid === 1'b1) seen = 1;
    end
    checkOutput("mid_fetch_reached", seen, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_busy", int'(busy1), 0);
    checkOutput("mid_rst_valid", int'(if1.addr_valid), 0);
    checkOutput("mid_rst_addr", int'(if1.addr), 0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0;
    start1 = 1'b0; start3 = 1'b0; abort = 1'b0; blk_done = 1'b0;
    rdy = 1'b1; sel = 1'b0;
    n_tests = 0; n_fail = 0;
    set_cfg(4, 4, 2, 2, 0, 0, 1'b0);
    test_reset();
    test_seq_square();
    test_interleave();
    test_clip();
    test_multichannel();
    test_random_ready();
    test_error_control();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
